// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding, key roles and limits for the subsystem dispatcher
package sub_pkg;
    typedef enum logic [1:0] {ST_MENU, ST_LAUNCH, ST_RUN, ST_RETURN} state_t;
    localparam int KEY_QUIT  = 0;
    localparam int KEY_NEXT  = 1;
    localparam int KEY_PREV  = 2;
    localparam int KEY_OK    = 3;
    localparam int N_SUB_MAX = 16;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: tick-sampled two-sample debouncer with level and one-cycle rise outputs
module key_debounce #(
    parameter int W          = 7,
    parameter int DEB_CYCLES = 20000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] raw,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);
    localparam int CW = $clog2(DEB_CYCLES);
    logic [CW-1:0] cnt;
    logic [W-1:0]  s0, s1;
    logic          tick;
    assign tick = cnt == CW'(DEB_CYCLES - 1);
    // level follows only when both samples agree; a disagreement holds the old level
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt   <= '0;
            s0    <= '0;
            s1    <= '0;
            level <= '0;
            rise  <= '0;
        end else begin
            cnt   <= tick ? '0 : cnt + CW'(1);
            s0    <= tick ? raw : s0;
            s1    <= tick ? s0 : s1;
            level <= (s0 & s1) | (level & (s0 | s1));
            rise  <= s0 & s1 & ~level;
        end
endmodule

// File: rtl/sub_dispatch.sv
// sub_dispatch: key-driven menu that launches one active-low subsystem and waits for its done handshake
module sub_dispatch
    import sub_pkg::*;
#(
    parameter int N_SUB       = 4,
    parameter int DEB_CYCLES  = 20000,
    parameter int ARM_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           keys_raw,
    input  logic [N_SUB-1:0]     en_back,
    output logic [N_SUB-1:0]     en_sub,
    output logic [6:0]           keys,
    output logic [N_SUB_MAX-1:0] menu_led,
    output logic                 busy,
    output logic                 err
);
    localparam int SW = $clog2(N_SUB);
    localparam int TW = $clog2(ARM_TIMEOUT + 1);
    logic [6:0]       kp;
    logic [N_SUB-1:0] eb1, eb2;
    logic [SW-1:0]    sel, nsel;
    logic [TW-1:0]    wd;
    logic             next, prev, back, unused_kp;
    state_t           state;
    key_debounce #(.W(7), .DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (keys_raw),
        .level (keys),
        .rise  (kp)
    );
    assign next      = kp[KEY_NEXT];
    assign prev      = kp[KEY_PREV];
    assign back      = eb2[sel];
    assign unused_kp = ^{kp[6:4], kp[KEY_QUIT]};
    always_comb
        nsel = next ? (sel == SW'(N_SUB - 1) ? '0 : sel + SW'(1))
                    : (sel == '0 ? SW'(N_SUB - 1) : sel - SW'(1));
    // the watchdog value doubles as the elapsed-cycle count that masks the stale done flag
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= ST_MENU;
            sel      <= '0;
            wd       <= '0;
            eb1      <= '1;
            eb2      <= '1;
            en_sub   <= '1;
            menu_led <= N_SUB_MAX'(1);
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            eb1 <= en_back;
            eb2 <= eb1;
            case (state)
                ST_MENU:
                    if (kp[KEY_OK]) begin
                        state    <= ST_LAUNCH;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        wd       <= '0;
                        menu_led <= '0;
                        en_sub   <= ~(N_SUB'(1) << sel);
                    end else if (next ^ prev) begin
                        sel      <= nsel;
                        menu_led <= N_SUB_MAX'(1) << nsel;
                    end
                ST_LAUNCH: begin
                    wd <= wd + TW'(1);
                    if (!back && wd != '0)
                        state <= ST_RUN;
                    else if (wd == TW'(ARM_TIMEOUT - 1)) begin
                        err    <= 1'b1;
                        state  <= ST_RETURN;
                        en_sub <= '1;
                    end
                end
                ST_RUN:
                    if (back) begin
                        state  <= ST_RETURN;
                        en_sub <= '1;
                    end
                default: begin
                    state    <= ST_MENU;
                    busy     <= 1'b0;
                    menu_led <= N_SUB_MAX'(1) << sel;
                end
            endcase
        end
endmodule

// File: tb/tb_sub_dispatch.sv
// tb_sub_dispatch: randomized and directed checks of sub_dispatch against a cycle-level behavioural model
module tb_sub_dispatch;
    localparam int N = 3, DEB = 4, TO = 32;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [6:0]  keys_raw = '0;
    logic [2:0]  en_back = 3'b111;
    logic [2:0]  en_sub;
    logic [6:0]  keys;
    logic [15:0] menu_led;
    logic        busy, err;
    int          errors = 0, checks = 0;
    always #5 clk = ~clk;
    sub_dispatch #(.N_SUB(N), .DEB_CYCLES(DEB), .ARM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .keys_raw(keys_raw), .en_back(en_back),
        .en_sub(en_sub), .keys(keys), .menu_led(menu_led), .busy(busy), .err(err)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask
    // model: mode 0 menu, 1 launching, 2 running, 3 returning; driven by observed key edges and pin history
    int         m_mode = 0, m_sel = 0, m_lc = 0;
    logic       m_err = 1'b0;
    logic [6:0] k1 = '0, k2 = '0;
    logic [2:0] p0 = 3'b111, p1 = 3'b111, p2 = 3'b111;
    always @(posedge clk) begin
        logic [6:0] kp;
        logic       eb;
        p2 = p1;
        p1 = p0;
        p0 = en_back;
        if (!rst_n) begin
            m_mode = 0;
            m_sel  = 0;
            m_lc   = 0;
            m_err  = 1'b0;
        end else begin
            kp = k1 & ~k2;
            eb = p2[m_sel];
            case (m_mode)
                0: if (kp[3]) begin
                       m_mode = 1;
                       m_err  = 1'b0;
                       m_lc   = 0;
                   end else if (kp[1] && !kp[2]) m_sel = (m_sel + 1) % N;
                   else if (kp[2] && !kp[1]) m_sel = (m_sel + N - 1) % N;
                1: begin
                       m_lc++;
                       if (!eb && m_lc >= 2) m_mode = 2;
                       else if (m_lc >= TO) begin
                           m_err  = 1'b1;
                           m_mode = 3;
                       end
                   end
                2: if (eb) m_mode = 3;
                default: m_mode = 0;
            endcase
        end
        #1;
        chk("m_en_sub", en_sub, (m_mode == 1 || m_mode == 2) ? 3'(~(3'b001 << m_sel)) : 3'b111);
        chk("m_menu_led", menu_led, m_mode == 0 ? 16'(16'h1 << m_sel) : 16'h0);
        chk("m_busy", busy, m_mode != 0);
        chk("m_err", err, m_err);
        k2 = k1;
        k1 = keys;
    end
    task automatic press(input logic [6:0] m);
        int lat = 0;
        @(negedge clk);
        keys_raw = m;
        while ((keys & m) != m && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("key_latency", 32'(lat >= DEB + 1 && lat <= 2 * DEB + 1), 1);
        repeat (20 - lat) @(negedge clk);
        keys_raw = '0;
        repeat (20) @(negedge clk);
    endtask
    task automatic launch(input int i);
        int t = 0;
        @(negedge clk);
        keys_raw = 7'h08;
        while (en_sub[i] && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("launch_en_sub", en_sub, 3'(~(3'b001 << i)));
        keys_raw = '0;
        repeat (3) @(negedge clk);
        en_back[i] = 1'b0;
    endtask
    task automatic confirm_until_busy();
        int t = 0;
        @(negedge clk);
        keys_raw = 7'h08;
        while (!busy && t < 30) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("confirm_busy", busy, 1);
        keys_raw = '0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic seen;
        logic [6:0] pat;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_en_sub", en_sub, 3'b111);
        chk("idle_menu_led", menu_led, 16'h0001);
        chk("idle_busy", busy, 0);
        chk("idle_err", err, 0);
        chk("idle_keys", keys, 0);
        press(7'h02); chk("next1", menu_led, 16'h0002);
        press(7'h02); chk("next2", menu_led, 16'h0004);
        press(7'h02); chk("next_wrap", menu_led, 16'h0001);
        press(7'h04); chk("prev_wrap", menu_led, 16'h0004);
        press(7'h04); chk("prev", menu_led, 16'h0002);
        // subsystem 1 full handshake; a next press during RUN must not move the selection
        launch(1);
        repeat (20) @(negedge clk);
        keys_raw = 7'h02;
        repeat (30) @(negedge clk);
        keys_raw = '0;
        chk("run_en_sub", en_sub, 3'b101);
        chk("run_busy", busy, 1);
        en_back[1] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("ret_still_low", en_sub, 3'b101);
        @(posedge clk); #1;
        chk("ret_released", en_sub, 3'b111);
        @(posedge clk); #1;
        chk("ret_menu_led", menu_led, 16'h0002);
        chk("ret_busy", busy, 0);
        repeat (20) @(negedge clk);
        // subsystem 2 never acknowledges
        press(7'h02); chk("sel2", menu_led, 16'h0004);
        confirm_until_busy();
        chk("to_en_sub", en_sub, 3'b011);
        repeat (31) begin @(posedge clk); #1; end
        chk("to_err_before", err, 0);
        chk("to_en_before", en_sub, 3'b011);
        @(posedge clk); #1;
        chk("to_err", err, 1);
        chk("to_en_sub_rel", en_sub, 3'b111);
        repeat (20) @(negedge clk);
        chk("to_menu", menu_led, 16'h0004);
        chk("to_busy", busy, 0);
        chk("to_err_sticky", err, 1);
        confirm_until_busy();
        chk("err_cleared", err, 0);
        repeat (60) @(negedge clk);
        // glitch shorter than the sampling period
        keys_raw = 7'h10;
        repeat (3) @(negedge clk);
        keys_raw = '0;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); seen |= |keys; end
        chk("glitch_keys", seen, 0);
        press(7'h06); chk("next_prev_same", menu_led, 16'h0004);
        // asynchronous reset in the middle of a run of subsystem 1
        press(7'h02); chk("sel0", menu_led, 16'h0001);
        press(7'h02); chk("sel1", menu_led, 16'h0002);
        launch(1);
        repeat (10) @(negedge clk);
        chk("run1_en_sub", en_sub, 3'b101);
        rst_n = 1'b0;
        #1;
        chk("arst_en_sub", en_sub, 3'b111);
        chk("arst_menu_led", menu_led, 16'h0001);
        chk("arst_busy", busy, 0);
        repeat (2) @(negedge clk);
        en_back = 3'b111;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        // random key patterns and done flags, held long enough to settle through the debouncer
        repeat (60) begin
            pat = 7'($urandom_range(0, 127));
            keys_raw = pat;
            en_back = 3'($urandom);
            repeat (12) @(negedge clk);
            chk("rand_keys", keys, pat);
        end
        keys_raw = '0;
        en_back = 3'b111;
        repeat (60) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sub_dispatch.md
# sub_dispatch

Front-end menu/dispatcher that sits directly upstream of the LED subsystems (subsystem 0 = LED scanner). It debounces the seven board keys, lets the user step through subsystems on a one-hot LED menu, then launches the chosen subsystem by pulling its active-low `en_sub` low. It waits for that subsystem's `en_back` handshake and returns to the menu, with a launch watchdog for subsystems that never acknowledge.

## Interface
- `N_SUB`, 4: number of subsystems, 2..16.
- `DEB_CYCLES`, 20000: clk cycles between debounce samples, ≥2.
- `ARM_TIMEOUT`, 1024: max cycles in LAUNCH waiting for `en_back` low.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `keys_raw`  in  7  raw key pins, active-high, asynchronous to clk.
- `en_back`  in  N_SUB  per-subsystem done flag, asynchronous; 2-flop synchronised inside.
- `en_sub`  out  N_SUB  per-subsystem enable, active-low; at most one bit low.
- `keys`  out  7  debounced key levels, fanned out to all subsystems.
- `menu_led`  out  16  one-hot of current selection in MENU, 0 otherwise.
- `busy`  out  1  high in LAUNCH/RUN/RETURN.
- `err`  out  1  sticky launch-timeout flag.

## Operation
- Reset values: `en_sub` all 1, `keys` 0, `menu_led` 16'h0001, `busy` 0, `err` 0, `sel` 0, state MENU.
- Debounce: a shared tick fires every `DEB_CYCLES`; each key has a 2-bit sample shift. `keys[i]` updates only when both samples agree. Rising-edge pulses `kp[i]` are one cycle wide.
- Key roles: `keys[0]` force-quit (consumed by subsystems, ignored here), `kp[1]` next, `kp[2]` prev, `kp[3]` confirm. Other keys are pass-through only.
- MENU:
  - next: `sel` = `sel`+1, wrapping N_SUB-1→0.
  - prev: `sel` = `sel`-1, wrapping 0→N_SUB-1.
  - next and prev in the same cycle: no change.
  - confirm: clear `err`, go to LAUNCH. Confirm wins over next/prev in the same cycle and uses the pre-update `sel`.
- LAUNCH:
  - `en_sub[sel]` is driven 0; a cycle counter starts.
  - Go to RUN once synced `en_back[sel]`==0 and at least 2 cycles have elapsed. This ignores the stale high left by the subsystem's previous exit.
  - If the counter reaches `ARM_TIMEOUT`: set `err`, go to RETURN.
- RUN:
  - `en_sub[sel]` stays 0.
  - Synced `en_back[sel]` rising to 1 → RETURN.
  - Key pulses are ignored for menu purposes.
- RETURN: drive all `en_sub` to 1 for exactly 1 cycle, then MENU. `sel` is kept.
- `sel` is `$clog2(N_SUB)` bits wide, with explicit compare against N_SUB-1 for wrap (non-power-of-2 safe). `menu_led` = 16'b1 << `sel`.
- If `rst_n` is asserted mid-RUN, `en_sub` goes all-1 immediately (asynchronous), so the subsystem sees enable withdrawn.

## Timing
- Key press to `keys` level: between `DEB_CYCLES`+1 and 2·`DEB_CYCLES`+1 cycles. Glitches shorter than one tick period are never seen.
- `kp` to `sel`/`menu_led` change: 1 cycle.
- `kp[3]` to `en_sub[sel]` low: 1 cycle.
- `en_back` pin to its synced value: 2 cycles. Synced rise to `en_sub` high: 1 cycle, then MENU 1 cycle later.
- All outputs are registered; no combinational input→output path.

## Structure
- Shared package `sub_pkg`:
  - state encoding (MENU, LAUNCH, RUN, RETURN);
  - key index constants (`KEY_QUIT`=0, `KEY_NEXT`=1, `KEY_PREV`=2, `KEY_OK`=3);
  - `N_SUB_MAX`=16.
- Sub-module `key_debounce`: tick counter, per-bit sample shift, level and rise-pulse outputs, parameterised by width and `DEB_CYCLES`.
- `sub_dispatch`: synchronisers, FSM, `sel`, watchdog counter, output registers.

## Test plan
Bench uses `DEB_CYCLES`=4, `ARM_TIMEOUT`=32, `N_SUB`=3.
- Reset then idle 100 cycles → `en_sub`=3'b111, `menu_led`=16'h0001, `busy`=0, `err`=0.
- 3× next, then 1× prev, each press held 20 cycles → `menu_led` steps 0002, 0004, 0001 (wrap), then 0004 (wrap back).
- Model subsystem 1:
  - Setup: `en_back`=1 initially, drops 3 cycles after `en_sub[1]` falls.
  - Stimulus: select 1, confirm, raise `en_back[1]` 50 cycles later.
  - Required: `en_sub`=3'b101 during RUN; all 1 exactly 3 cycles after the `en_back` pin rises; `menu_led`=0002 again.
- Launch subsystem 2 with `en_back[2]` stuck at 1 → after 32 cycles, `err`=1, `en_sub`=3'b111, state MENU. The next confirm clears `err`.
- Key pulse of 3 cycles (shorter than tick) → `keys` unchanged. Next and prev pressed on the same cycle → `sel` unchanged.
- `rst_n` low mid-RUN → `en_sub`=3'b111 within the same cycle, `sel`=0, `menu_led`=0001.
